// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings
// and the {main_valid, skid_valid} state encoding.
package imm_ext_pkg;

  // Extension modes as they arrive from decode-field extraction.
  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_BR   = 2'b11
  } ext_mode_t;

  // Occupancy state, encoded as {main_valid, skid_valid}; 2'b01 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_t;

  localparam int CNT_W = 32;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, upper (LUI) and branch
// offset (sign-extended, shifted left 2). Reusable by any stage.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] result
);

  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  assign sext = {{E{imm[IN_W-1]}}, imm};

  // Select the extension form for the requested mode.
  always_comb begin
    result = '0;
    case (mode)
      EXT_ZERO: result = {{E{1'b0}}, imm};
      EXT_SIGN: result = sext;
      EXT_LUI:  result = {imm, {E{1'b0}}};
      EXT_BR:   result = {sext[OUT_W-3:0], 2'b00};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a registered valid/ready stage and a
// 2-entry skid buffer (main register drives out_*, skid absorbs one extra
// entry so in_ready can come straight from a flop).
// Optional: define IMM_EXT_PIPE_CNT_EN to enable the output-handshake
// counter on ext_count; otherwise ext_count is tied to 0.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] ext_count
);

  // The branch form needs room for a sign bit plus the 2-bit shift.
  generate
    if (!(OUT_W > IN_W + 1)) begin : g_bad_widths
      $error("imm_ext_pipe: OUT_W must exceed IN_W + 1");
    end
  endgenerate

  pipe_state_t      state, state_nx;
  logic [OUT_W-1:0] ext_res;
  logic [OUT_W-1:0] main_q, skid_q;
  logic             in_ready_q;
  logic             acc, deq;
  logic             load_main, load_skid, skid_to_main;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm    (in_imm),
    .mode   (ext_mode_t'(in_mode)),
    .result (ext_res)
  );

  assign acc       = in_valid && in_ready_q;
  assign deq       = state[1] && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = state[1];
  assign out_data  = main_q;

  // Next occupancy state and data-path steering from the two handshakes.
  always_comb begin
    state_nx     = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nx  = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && deq) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_nx  = ST_FULL;
          load_skid = 1'b1;
        end else if (deq) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (deq) begin
          state_nx     = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
    // Flush drops everything, including any same-cycle accept.
    if (flush) state_nx = ST_EMPTY;
  end

  // State register; in_ready is precomputed from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != ST_FULL);
    end
  end

  // Data registers; held while stalled so out_data stays stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= ext_res;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= ext_res;
    end
  end

`ifdef IMM_EXT_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count delivered results; flush cancels the count, only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset)              cnt_q <= '0;
    else if (deq && !flush)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ext_count = cnt_q;
`else
  assign ext_count = '0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a queue-based occupancy model checked every cycle,
// plus hand-computed literal checks on captured outputs.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_data, ext_count;

  logic        in_valid8, out_ready8, in_ready8, out_valid8;
  logic [7:0]  in_imm8;
  logic [1:0]  in_mode8;
  logic [15:0] out_data8;
  logic [31:0] ext_count8;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic [31:0] mq[$];
  logic [31:0] mcnt = 0;
  logic [31:0] got[$];
  logic [15:0] got8[$];
`ifdef IMM_EXT_PIPE_CNT_EN
  logic [31:0] cnt_base = 0;
`endif

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ext_count(ext_count)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid8),
    .in_ready(in_ready8), .in_imm(in_imm8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .ext_count(ext_count8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Extension rule stated arithmetically on unsigned values.
  function automatic longint ext(input longint imm, input int mode, input int inw, input int outw);
    longint m, s;
    m = longint'(1) << outw;
    s = (imm >= (longint'(1) << (inw - 1))) ? imm + m - (longint'(1) << inw) : imm;
    case (mode)
      0:       return imm;
      1:       return s;
      2:       return imm * (longint'(1) << (outw - inw));
      default: return (s * 4) % m;
    endcase
  endfunction

  // Compare against the model mid-cycle, then advance the model with the
  // inputs that will be sampled at the next rising edge.
  always @(negedge clk) begin
    bit acc, deq;
    if (chk_en) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
`ifdef IMM_EXT_PIPE_CNT_EN
      chk("ext_count", ext_count, 32'(mcnt + cnt_base));
`else
      chk("ext_count", ext_count, 0);
`endif
      if (out_valid && out_ready) got.push_back(out_data);
      if (out_valid8 && out_ready8) got8.push_back(out_data8);
    end
    acc = in_valid && (mq.size() < 2);
    deq = (mq.size() > 0) && out_ready;
    if (!reset) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (deq) begin
        void'(mq.pop_front());
        mcnt = mcnt + 1;
      end
      if (acc) mq.push_back(32'(ext(longint'(in_imm), int'(in_mode), 16, 32)));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] imm, input logic [1:0] mode);
    in_valid = 1'b1; in_imm = imm; in_mode = mode;
    step();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_mode = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_imm8 = '0; in_mode8 = '0;

    // Reset for two cycles.
    step();
    chk_en = 1;
    step();
    reset = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ext_count", ext_count, 0);
    chk("rst_out_data", out_data, 0);

    // All four modes back-to-back with the consumer always ready.
    out_ready = 1'b1;
    got.delete();
    for (int m = 0; m < 4; m++) push(16'h8001, 2'(m));
    in_valid = 1'b0;
    step(2);
    chk("modes_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("mode_zero", got[0], 32'h0000_8001);
      chk("mode_sign", got[1], 32'hFFFF_8001);
      chk("mode_lui",  got[2], 32'h8001_0000);
      chk("mode_br",   got[3], 32'hFFFE_0004);
    end

    // Back-pressure fills main and skid, then drains in order.
    out_ready = 1'b0;
    push(16'h0001, 2'b01);
    push(16'h7FFF, 2'b00);
    in_valid = 1'b0;
    step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold0", out_data, 32'h0000_0001);
    step();
    chk("bp_hold1", out_data, 32'h0000_0001);
    got.delete();
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", in_ready, 1);
    step(2);
    chk("bp_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("bp_first", got[0], 32'h0000_0001);
      chk("bp_second", got[1], 32'h0000_7FFF);
    end

    // Flush from FULL with a simultaneous input.
    out_ready = 1'b0;
    push(16'h0011, 2'b00);
    push(16'h0022, 2'b00);
    flush = 1'b1;
    push(16'h0033, 2'b00);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    got.delete();
    out_ready = 1'b1;
    step(3);
    chk("fl_nothing_out", got.size(), 0);

    // Counter: fresh reset, five deliveries, then a flush.
    reset = 1'b0;
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(16'(i + 1), 2'b00);
    in_valid = 1'b0;
    step(2);
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef IMM_EXT_PIPE_CNT_EN
    chk("cnt_five", ext_count, 5);
    force dut.cnt_q = 32'hFFFF_FFFF;
    cnt_base = 32'hFFFF_FFFF - mcnt;
    step();
    release dut.cnt_q;
    push(16'h0042, 2'b00);
    in_valid = 1'b0;
    step(2);
    chk("cnt_wrap", ext_count, 0);
`else
    chk("cnt_off", ext_count, 0);
`endif

    // Narrow instance: 8-bit in, 16-bit out.
    got8.delete();
    in_valid8 = 1'b1; in_imm8 = 8'hF0; in_mode8 = 2'b01;
    step();
    in_mode8 = 2'b11;
    step();
    in_valid8 = 1'b0;
    step(2);
    chk("w8_n", got8.size(), 2);
    if (got8.size() == 2) begin
      chk("w8_sign", got8[0], 16'hFFF0);
      chk("w8_br",   got8[1], 16'hFFC0);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS datapath; successor to the single-mode combinational sign/zero extender.
- Four extension modes, configurable input and output widths, and a registered valid/ready stage with a 2-entry skid buffer.
- Sits between decode-field extraction and the operand mux.
- Supports back-pressure and flush without a combinational ready path.

Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: extended output width. Must satisfy OUT_W > IN_W + 1; elaboration fails otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; state clears on a rising clk edge while reset==0.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  in_imm/in_mode are valid.
- in_ready  output  1  unit can accept an entry; driven directly from a register.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode: 00 zero-ext, 01 sign-ext, 10 upper (LUI), 11 branch offset.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  OUT_W  extended result.
- ext_count  output  32  accepted-output counter (see Optional Feature).

Behaviour:
- Arithmetic, with E = OUT_W-IN_W:
  - mode 00: {E zeros, in_imm}.
  - mode 01: {E copies of in_imm[IN_W-1], in_imm}.
  - mode 10: {in_imm, E zeros}.
  - mode 11: mode-01 result shifted left 2, upper bits discarded, two LSBs zero.
- Extension is computed combinationally on the input side; only the result is stored.
- Storage is a main register (drives out_*) plus a skid register.
- in_ready = !skid_valid, registered.
- Input handshake when in_valid&&in_ready; output handshake when out_valid&&out_ready.
- Latency: an accepted entry appears on out_data the next cycle when the main register is empty or draining.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- States, encoded as {main_valid, skid_valid}:
  - EMPTY(00), ONE(10), FULL(11). State 01 is illegal.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + out handshake -> ONE, main loaded with new data.
  - ONE + accept, no out handshake -> FULL, new data goes to skid.
  - ONE + out handshake only -> EMPTY.
  - FULL + out handshake -> ONE, skid moves to main; no accept possible since in_ready=0.
  - FULL, no out handshake -> hold.
- Ordering is strictly FIFO. out_data must remain stable while out_valid=1 and out_ready=0.
- flush=1 (and reset=1): both valids clear next cycle and in_ready becomes 1. An input handshake in the same cycle is discarded. Data registers need not clear.
- reset=0 dominates flush. Reset values: out_valid=0, in_ready=1, out_data=0, ext_count=0, skid cleared.
- Reset mid-operation drops held entries, same as flush.
- An illegal mode encoding is impossible (2-bit field, all values defined).

Optional Feature:
- Macro IMM_EXT_PIPE_CNT_EN.
- Defined:
  - ext_count increments by 1 on every output handshake not overridden by flush/reset.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset only, not by flush.
- Undefined: the counter logic is absent and ext_count is tied to 0.

Decomposition:
- Shared package (imm_ext_pkg) holds:
  - mode constants EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_LUI=2'b10, EXT_BR=2'b11;
  - a 2-bit mode typedef;
  - the state encodings.
- One sub-module: imm_ext_core, purely combinational (in_imm, in_mode -> result), reusable by other stages.
- The top level holds the skid/handshake logic and the counter.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> out_valid=0, in_ready=1, ext_count=0.
- Modes with out_ready=1, in_imm=16'h8001 in modes 00/01/10/11 on consecutive cycles -> out_data 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004, each 1 cycle after accept, one per cycle.
- Back-pressure:
  - Stimulus: out_ready=0, push 16'h0001 mode 01, then 16'h7FFF mode 00.
  - Response: FULL state and in_ready=0. out_data holds 0x00000001 steady.
  - Then out_ready=1: outputs 0x00000001 then 0x00007FFF in order, and in_ready returns 1 the cycle after the first drain.
- Flush: in FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Counter:
  - With IMM_EXT_PIPE_CNT_EN, 5 output handshakes then 1 flush -> ext_count=5.
  - Force the counter to 0xFFFFFFFF, then one handshake -> ext_count=0.
  - Without the macro, ext_count stays 0 throughout.
- Parameterisation: IN_W=8, OUT_W=16, in_imm=8'hF0 in modes 01/11 -> 0xFFF0 and 0xFFC0.
